// File: rtl/sr_serial_tx_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sr_serial_tx_ctrl_if                                            |
// | Brief    : Word-accept handshake between a source and sr_serial_tx_ctrl.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface sr_serial_tx_ctrl_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         msb_first;

    modport master (
        output in_valid,
        output in_data,
        output msb_first,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  msb_first,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/sr_serial_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sr_serial_tx_ctrl                                               |
// | Brief    : Loads a word into a universal shift register and shifts it out  |
// |            as a timed serial stream, LSB- or MSB-first.                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sr_serial_tx_ctrl #(
    parameter int   N            = 8,
    parameter int   CLKS_PER_BIT = 4,
    parameter logic IDLE_LVL     = 1'b1
) (
    input  wire logic                  clk,
    input  wire logic                  clear,
    sr_serial_tx_ctrl_if.slave         in_if,
    input  wire logic [N-1:0]          sr_Q,
    output logic      [$clog2(N)-1:0]  sr_S,
    output logic      [N-1:0]          sr_D,
    output logic                       sr_MSBin,
    output logic                       sr_LSBin,
    output logic                       tx_bit,
    output logic                       tx_active,
    output logic                       frame_done
);

    localparam int c_SW = $clog2(N);
    localparam int c_CW = $clog2(N);
    localparam int c_BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [c_SW-1:0] c_S_HOLD = c_SW'(0);
    localparam logic [c_SW-1:0] c_S_LOAD = c_SW'(1);
    localparam logic [c_SW-1:0] c_S_SHR  = c_SW'(2);
    localparam logic [c_SW-1:0] c_S_SHL  = c_SW'(3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_bit_cnt;
    logic [c_BW-1:0]   r_baud_cnt;
    logic [N-1:0]      r_data;
    logic              r_dir;

    logic              w_bit_end;
    logic              w_last_bit;
    logic              w_unused_q;

    assign w_bit_end  = (r_baud_cnt == c_BW'(CLKS_PER_BIT - 1));
    assign w_last_bit = (r_bit_cnt == c_CW'(N - 1));
    // Only the end bits of Q reach tx_bit; the rest is deliberately ignored.
    assign w_unused_q = ^sr_Q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_data     <= '0;
            r_dir      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_if.in_valid) begin
                        r_data  <= in_if.in_data;
                        r_dir   <= in_if.msb_first;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (w_last_bit) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sr_S = c_S_HOLD;
        case (r_state)
            ST_LOAD:  sr_S = c_S_LOAD;
            ST_SHIFT: begin
                // The final bit is held, never shifted past.
                if (w_bit_end && !w_last_bit) begin
                    sr_S = r_dir ? c_S_SHL : c_S_SHR;
                end
            end
            default:  sr_S = c_S_HOLD;
        endcase
    end

    // State is already IDLE during clear, so readiness must also be masked by it.
    assign in_if.in_ready = (r_state == ST_IDLE) && !clear;
    assign sr_D           = r_data;
    assign sr_MSBin       = IDLE_LVL;
    assign sr_LSBin       = IDLE_LVL;
    assign tx_active      = (r_state == ST_SHIFT);
    assign tx_bit         = (r_state == ST_SHIFT) ? (r_dir ? sr_Q[N-1] : sr_Q[0]) : IDLE_LVL;
    assign frame_done     = (r_state == ST_SHIFT) && w_bit_end && w_last_bit;

endmodule
`default_nettype wire

// File: tb/tb_sr_serial_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sr_serial_tx_ctrl                                            |
// | Brief    : Two controller instances (4 and 1 clocks per bit), each with a  |
// |            shift-register model, checked cycle by cycle against a framing  |
// |            model.                                                          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sr_serial_tx_ctrl;

    localparam int c_N = 8;

    logic clk   = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    logic             sel   = 1'b0;
    logic             valid = 1'b0;
    logic [c_N-1:0]   data  = '0;
    logic             dir   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    sr_serial_tx_ctrl_if #(.N(c_N)) a_if ();
    sr_serial_tx_ctrl_if #(.N(c_N)) b_if ();

    assign a_if.in_valid  = valid & ~sel;
    assign a_if.in_data   = data;
    assign a_if.msb_first = dir;
    assign b_if.in_valid  = valid & sel;
    assign b_if.in_data   = data;
    assign b_if.msb_first = dir;

    logic [c_N-1:0] a_Q, a_D, b_Q, b_D;
    logic [2:0]     a_S, b_S;
    logic a_msbin, a_lsbin, a_tx, a_act, a_fd;
    logic b_msbin, b_lsbin, b_tx, b_act, b_fd;

    sr_serial_tx_ctrl #(.N(c_N), .CLKS_PER_BIT(4), .IDLE_LVL(1'b1)) u_dut_a (
        .clk(clk), .clear(clear), .in_if(a_if), .sr_Q(a_Q), .sr_S(a_S), .sr_D(a_D),
        .sr_MSBin(a_msbin), .sr_LSBin(a_lsbin), .tx_bit(a_tx), .tx_active(a_act),
        .frame_done(a_fd)
    );

    sr_serial_tx_ctrl #(.N(c_N), .CLKS_PER_BIT(1), .IDLE_LVL(1'b1)) u_dut_b (
        .clk(clk), .clear(clear), .in_if(b_if), .sr_Q(b_Q), .sr_S(b_S), .sr_D(b_D),
        .sr_MSBin(b_msbin), .sr_LSBin(b_lsbin), .tx_bit(b_tx), .tx_active(b_act),
        .frame_done(b_fd)
    );

    // Universal shift register models: 0 HOLD, 1 LOAD, 2 SHR, 3 SHL.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) a_Q <= '0;
        else case (a_S)
            3'd1:    a_Q <= a_D;
            3'd2:    a_Q <= {a_msbin, a_Q[c_N-1:1]};
            3'd3:    a_Q <= {a_Q[c_N-2:0], a_lsbin};
            default: a_Q <= a_Q;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) b_Q <= '0;
        else case (b_S)
            3'd1:    b_Q <= b_D;
            3'd2:    b_Q <= {b_msbin, b_Q[c_N-1:1]};
            3'd3:    b_Q <= {b_Q[c_N-2:0], b_lsbin};
            default: b_Q <= b_Q;
        endcase
    end

    logic           o_rdy, o_tx, o_act, o_fd;
    logic [2:0]     o_S;
    logic [c_N-1:0] o_D;
    assign o_rdy = sel ? b_if.in_ready : a_if.in_ready;
    assign o_tx  = sel ? b_tx  : a_tx;
    assign o_act = sel ? b_act : a_act;
    assign o_fd  = sel ? b_fd  : a_fd;
    assign o_S   = sel ? b_S   : a_S;
    assign o_D   = sel ? b_D   : a_D;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_rdy);
        chk({tag, " in_ready"},   32'(o_rdy), 32'(exp_rdy));
        chk({tag, " sr_S"},       32'(o_S),   32'd0);
        chk({tag, " tx_bit"},     32'(o_tx),  32'd1);
        chk({tag, " tx_active"},  32'(o_act), 32'd0);
        chk({tag, " frame_done"}, 32'(o_fd),  32'd0);
    endtask

    // Called at a negedge while the selected DUT is idle: that cycle is the accept
    // cycle (k=0). Returns at the negedge of the frame_done cycle, or of cycle
    // abort_k if nonzero. hold keeps in_valid high with junk data mid-frame.
    task automatic send(input logic s, input logic [c_N-1:0] w, input logic d,
                         input logic hold, input int abort_k);
        int cpb, last, j, i, ph;
        logic exp_tx, exp_fd;
        logic [2:0] exp_S;
        sel   = s;
        valid = 1'b1;
        data  = w;
        dir   = d;
        cpb   = s ? 1 : 4;
        last  = 1 + c_N * cpb;
        #1;
        chk_idle($sformatf("accept w=%02h d=%0d", w, d), 1'b1);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (abort_k != 0 && k == abort_k) return;
            valid = hold;
            data  = c_N'($urandom);
            dir   = 1'($urandom);
            if (k == 1) begin
                exp_S = 3'd1; exp_tx = 1'b1; exp_fd = 1'b0;
                chk($sformatf("w=%02h k=1 sr_D", w), 32'(o_D), 32'(w));
            end else begin
                j  = k - 2;
                i  = j / cpb;
                ph = j % cpb;
                exp_tx = d ? w[c_N-1-i] : w[i];
                exp_S  = (ph == cpb - 1 && i < c_N - 1) ? (d ? 3'd3 : 3'd2) : 3'd0;
                exp_fd = (ph == cpb - 1 && i == c_N - 1);
            end
            chk($sformatf("w=%02h d=%0d k=%0d tx_bit", w, d, k),     32'(o_tx),  32'(exp_tx));
            chk($sformatf("w=%02h d=%0d k=%0d sr_S", w, d, k),       32'(o_S),   32'(exp_S));
            chk($sformatf("w=%02h d=%0d k=%0d frame_done", w, d, k), 32'(o_fd),  32'(exp_fd));
            chk($sformatf("w=%02h d=%0d k=%0d tx_active", w, d, k),  32'(o_act), 32'(k >= 2));
            chk($sformatf("w=%02h d=%0d k=%0d in_ready", w, d, k),   32'(o_rdy), 32'd0);
        end
    endtask

    initial begin
        // Reset held: outputs idle and not ready
        repeat (3) @(negedge clk);
        sel = 1'b0; #1; chk_idle("reset A", 1'b0);
        sel = 1'b1; #1; chk_idle("reset B", 1'b0);
        clear = 1'b0; #1;
        chk_idle("release B", 1'b1);
        sel = 1'b0; #1; chk_idle("release A", 1'b1);

        // No traffic for 50 cycles
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            sel = 1'b0; #1; chk_idle("quiet A", 1'b1);
            sel = 1'b1; #1; chk_idle("quiet B", 1'b1);
        end

        // Directed frames
        @(negedge clk); send(1'b0, 8'hA5, 1'b0, 1'b0, 0);
        @(negedge clk); send(1'b0, 8'hA5, 1'b1, 1'b0, 0);
        @(negedge clk); send(1'b0, 8'h3C, 1'b0, 1'b1, 0);
        @(negedge clk); send(1'b0, 8'hC3, 1'b1, 1'b0, 0);
        @(negedge clk); send(1'b1, 8'h01, 1'b0, 1'b0, 0);
        @(negedge clk); send(1'b1, 8'h80, 1'b1, 1'b1, 0);

        // Random frames on both instances
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            send(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        // Clear in cycle 12 of a frame, then a fresh frame
        @(negedge clk);
        send(1'b0, 8'h5A, 1'b0, 1'b0, 12);
        valid = 1'b0;
        clear = 1'b1; #1;
        chk_idle("clear mid-frame", 1'b0);
        @(negedge clk);
        clear = 1'b0; #1;
        chk_idle("after release", 1'b1);
        send(1'b0, 8'h96, 1'b1, 1'b0, 0);
        @(negedge clk);
        valid = 1'b0;
        send(1'b0, 8'h6B, 1'b0, 1'b0, 0);
        @(negedge clk);
        valid = 1'b0; #1;
        chk_idle("final", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
